avalon_bus_fabric: RTL

Parametrised successor to the fixed three-device data bus. It decodes a single master's load/store strobes onto NDEV Avalon-style slave ports selected by the top DEVB address bits. Each access is tracked by a transaction FSM with registered read data, per-slave wait-request handshaking, an unmapped-address error response and an optional watchdog timeout. It sits between the pipeline's memory stage and the memory, on-chip and IO slaves.

---
 rtl/avalon_bus_fabric_if.sv | 33 +++
 rtl/avalon_bus_fabric.sv | 124 ++++++++++++
 2 files changed

// File: rtl/avalon_bus_fabric_if.sv
// Master-side and slave-side signal bundle for avalon_bus_fabric.
// The fabric connects through the slave modport; the CPU/slave environment uses master.
interface avalon_bus_fabric_if #(
    parameter int DW   = 16,
    parameter int AW   = 16,
    parameter int DEVB = 4,
    parameter int NDEV = 3
);
    logic                 ReadData;
    logic                 WriteData;
    logic [AW-1:0]        DataAddr;
    logic [DW-1:0]        BusIn;
    logic [DW-1:0]        BusOut;
    logic                 DataDone;
    logic                 BusError;
    logic [7:0]           ErrCount;
    logic [NDEV-1:0]      SlvRead;
    logic [NDEV-1:0]      SlvWrite;
    logic [AW-DEVB-1:0]   SlvAddr;
    logic [DW-1:0]        SlvWdata;
    logic [NDEV*DW-1:0]   SlvRdata;
    logic [NDEV-1:0]      SlvWaitreq;

    modport master (
        output ReadData, WriteData, DataAddr, BusIn, SlvRdata, SlvWaitreq,
        input  BusOut, DataDone, BusError, ErrCount, SlvRead, SlvWrite, SlvAddr, SlvWdata
    );

    modport slave (
        input  ReadData, WriteData, DataAddr, BusIn, SlvRdata, SlvWaitreq,
        output BusOut, DataDone, BusError, ErrCount, SlvRead, SlvWrite, SlvAddr, SlvWdata
    );
endinterface

// File: rtl/avalon_bus_fabric.sv
// Single-master to NDEV-slave Avalon-style bus fabric with wait-request handshake and error response.
// Optional watchdog abort of stalled accesses is built when BUS_TIMEOUT_EN is defined.
module avalon_bus_fabric #(
    parameter int DW      = 16,
    parameter int AW      = 16,
    parameter int DEVB    = 4,
    parameter int NDEV    = 3,
    parameter int TIMEOUT = 255
) (
    input  logic              Clock,
    input  logic              Reset,
    avalon_bus_fabric_if.slave bus
);
    localparam int OW = AW - DEVB;

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE, RELEASE} state_t;

    state_t          state;
    state_t          next_state;
    logic [DEVB-1:0] dev_q;
    logic [OW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   rdata_q;
    logic            write_q;
    logic            err_q;
    logic [7:0]      err_count;

    logic [DEVB-1:0] dev_in;
    logic            mapped;
    logic            request;
    logic            sel_wait;
    logic [DW-1:0]   sel_rdata;
    logic            timeout_hit;

    assign request = bus.ReadData | bus.WriteData;
    assign dev_in  = bus.DataAddr[AW-1 -: DEVB];
    assign mapped  = int'(dev_in) < NDEV;

    always_comb begin
        sel_wait  = 1'b1;
        sel_rdata = '0;
        for (int i = 0; i < NDEV; i++) begin
            if (dev_q == DEVB'(i)) begin
                sel_wait  = bus.SlvWaitreq[i];
                sel_rdata = bus.SlvRdata[i*DW +: DW];
            end
        end
    end

    // Strobes are gated by Reset so an abandoned access releases the slave immediately.
    always_comb begin
        bus.SlvRead  = '0;
        bus.SlvWrite = '0;
        for (int i = 0; i < NDEV; i++) begin
            if (state == ACTIVE && !Reset && dev_q == DEVB'(i)) begin
                bus.SlvRead[i]  = !write_q;
                bus.SlvWrite[i] = write_q;
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wd_count;

    always_ff @(posedge Clock) begin
        if (Reset || state != ACTIVE) wd_count <= '0;
        else                          wd_count <= wd_count + TW'(1);
    end

    assign timeout_hit = (state == ACTIVE) && sel_wait && (wd_count == TW'(TIMEOUT - 1));
`else
    // TIMEOUT has no effect without the watchdog; ACTIVE waits for the slave indefinitely.
    localparam bit WatchdogBuilt = (TIMEOUT < 0);
    assign timeout_hit = WatchdogBuilt;
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (request) next_state = mapped ? ACTIVE : DONE;
            ACTIVE:  if (!sel_wait || timeout_hit) next_state = DONE;
            DONE:    next_state = RELEASE;
            RELEASE: if (!request) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            dev_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            err_count <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && request) begin
                dev_q   <= dev_in;
                addr_q  <= bus.DataAddr[OW-1:0];
                wdata_q <= bus.BusIn;
                write_q <= bus.WriteData;
                err_q   <= !mapped;
                if (!mapped) rdata_q <= '0;
            end
            if (state == ACTIVE && !sel_wait && !write_q) rdata_q <= sel_rdata;
            if (timeout_hit) begin
                err_q   <= 1'b1;
                rdata_q <= '0;
            end
            if (state == DONE && err_q && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

    assign bus.DataDone = (state == DONE);
    assign bus.BusError = (state == DONE) && err_q;
    assign bus.BusOut   = rdata_q;
    assign bus.ErrCount = err_count;
    assign bus.SlvAddr  = addr_q;
    assign bus.SlvWdata = wdata_q;
endmodule
